// File: rtl/cp_outbuf_rdctrl_if.sv
// ---------------------------------------------------------------------------
// cp_outbuf_rdctrl_if
// Bundles the signals of the CP output-buffer read controller:
//   control : iStart, iAbort, iStAddr[6:0], iBlkCnt[7:0], oBusy, oDone
//   buffer  : oRdEn_OutBuf, oRdAddr_OutBuf[8:0], iRdDt_OutBuf[31:0]
//   stream  : oDt[31:0], oDtVld, iDtRdy
// The slave modport is the controller's view; master is the view of the
// logic that drives it (sequencer, output buffer and stream sink together).
// ---------------------------------------------------------------------------
interface cp_outbuf_rdctrl_if;
    logic        iStart;
    logic        iAbort;
    logic [6:0]  iStAddr;
    logic [7:0]  iBlkCnt;
    logic        oRdEn_OutBuf;
    logic [8:0]  oRdAddr_OutBuf;
    logic [31:0] iRdDt_OutBuf;
    logic [31:0] oDt;
    logic        oDtVld;
    logic        iDtRdy;
    logic        oBusy;
    logic        oDone;

    modport slave (
        input  iStart, iAbort, iStAddr, iBlkCnt, iRdDt_OutBuf, iDtRdy,
        output oRdEn_OutBuf, oRdAddr_OutBuf, oDt, oDtVld, oBusy, oDone
    );

    modport master (
        output iStart, iAbort, iStAddr, iBlkCnt, iRdDt_OutBuf, iDtRdy,
        input  oRdEn_OutBuf, oRdAddr_OutBuf, oDt, oDtVld, oBusy, oDone
    );
endinterface

// File: rtl/cp_outbuf_rdctrl.sv
// ---------------------------------------------------------------------------
// cp_outbuf_rdctrl
// Drains a range of 128-bit blocks out of the CP output buffer through its
// 32-bit read port and streams the words downstream with a valid/ready
// handshake. A small output FIFO absorbs the one-cycle read latency; reads
// are only issued when a FIFO slot is guaranteed, so the FIFO cannot
// overflow under any amount of backpressure.
//
// Ports
//   iClk   : clock, all state updates on rising edge
//   iRst   : synchronous active-high reset
//   bus    : cp_outbuf_rdctrl_if.slave
//     iStart/iAbort       start a drain / abandon the current drain
//     iStAddr/iBlkCnt     first block index and number of blocks (0..128)
//     oRdEn_OutBuf        read strobe, oRdAddr_OutBuf = {block, lane}
//     iRdDt_OutBuf        read data, valid one cycle after the strobe
//     oDt/oDtVld/iDtRdy   output word stream (FIFO head)
//     oBusy/oDone         activity flag / one-cycle completion pulse
// Parameter
//   P_FIFO_DEPTH : output FIFO entries, 2..4
// ---------------------------------------------------------------------------
module cp_outbuf_rdctrl #(
    parameter int P_FIFO_DEPTH = 2
) (
    input  logic                 iClk,
    input  logic                 iRst,
    cp_outbuf_rdctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      stateNxt;

    logic [8:0]  wordAddr;     // next 32-bit word to read
    logic [9:0]  remCnt;       // words still to be read (up to 512)
    logic        rdVld_p1;     // a read was issued last cycle; data is on iRdDt_OutBuf now

    // Storage is sized for the largest legal depth; only P_FIFO_DEPTH
    // entries are ever addressed.
    logic [31:0] fifoMem [4];
    logic [1:0]  wrPtr;
    logic [1:0]  rdPtr;
    logic [2:0]  fifoCnt;

    logic        startOk;
    logic        abortRun;
    logic        popNow;
    logic        push;
    logic [3:0]  occ;
    logic        creditOk;
    logic        issue;
    logic        lastIssue;
    logic        lastPop;
    logic        dtVld;
    logic        busyC;
    logic        doneC;

    // Circular pointer advance for a depth that need not be a power of two.
    function automatic logic [1:0] ptrInc(input logic [1:0] p);
        ptrInc = (p == 2'(P_FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign startOk  = (state == IDLE) && bus.iStart && !bus.iAbort;
    assign abortRun = ((state == RUN) || (state == DRAIN)) && bus.iAbort;

    assign dtVld    = (fifoCnt != 3'd0);
    assign popNow   = dtVld && bus.iDtRdy;

    // Returning data is only kept if the drain it belongs to is still alive.
    assign push     = rdVld_p1 && !abortRun;

    // Slots that will be taken after this edge if no new read is issued:
    // current entries plus the word in flight, minus the one leaving now.
    // A pop implies fifoCnt >= 1, so this never underflows.
    assign occ      = {1'b0, fifoCnt} + {3'b000, rdVld_p1} - {3'b000, popNow};
    assign creditOk = (occ < 4'(P_FIFO_DEPTH));

    assign issue     = (state == RUN) && !bus.iAbort && (remCnt != 10'd0) && creditOk;
    assign lastIssue = issue && (remCnt == 10'd1);

    // The final word leaves with nothing behind it in the FIFO or in flight.
    assign lastPop   = popNow && (fifoCnt == 3'd1) && !rdVld_p1;

    // ---- FSM state register ----
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // ---- FSM next state and status outputs ----
    always_comb begin
        stateNxt = state;
        busyC    = 1'b0;
        doneC    = 1'b0;
        case (state)
            IDLE: begin
                if (startOk) begin
                    stateNxt = (bus.iBlkCnt == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                busyC = 1'b1;
                if (bus.iAbort) begin
                    stateNxt = IDLE;
                end else if (lastIssue) begin
                    stateNxt = DRAIN;
                end
            end
            DRAIN: begin
                busyC = 1'b1;
                if (bus.iAbort) begin
                    stateNxt = IDLE;
                end else if (lastPop) begin
                    stateNxt = DONE;
                end
            end
            DONE: begin
                // Abort has no effect here; the pulse always completes.
                busyC    = 1'b1;
                doneC    = 1'b1;
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // ---- read issue: address, remaining count, in-flight flag ----
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wordAddr <= 9'd0;
            remCnt   <= 10'd0;
            rdVld_p1 <= 1'b0;
        end else begin
            rdVld_p1 <= issue;
            if (startOk && (bus.iBlkCnt != 8'd0)) begin
                wordAddr <= {bus.iStAddr, 2'b00};
                remCnt   <= {bus.iBlkCnt, 2'b00};
            end else if (abortRun) begin
                remCnt   <= 10'd0;
            end else if (issue) begin
                // 9-bit address wraps 511 -> 0 on its own.
                wordAddr <= wordAddr + 9'd1;
                remCnt   <= remCnt - 10'd1;
            end
        end
    end

    // ---- output FIFO control ----
    always_ff @(posedge iClk) begin
        if (iRst || abortRun) begin
            wrPtr   <= 2'd0;
            rdPtr   <= 2'd0;
            fifoCnt <= 3'd0;
        end else begin
            if (push) begin
                wrPtr <= ptrInc(wrPtr);
            end
            if (popNow) begin
                rdPtr <= ptrInc(rdPtr);
            end
            fifoCnt <= fifoCnt + {2'b00, push} - {2'b00, popNow};
        end
    end

    // ---- output FIFO storage (data only, not reset) ----
    always_ff @(posedge iClk) begin
        if (push) begin
            fifoMem[wrPtr] <= bus.iRdDt_OutBuf;
        end
    end

    // ---- outputs ----
    assign bus.oRdEn_OutBuf   = issue;
    assign bus.oRdAddr_OutBuf = wordAddr;
    // The head is forced to zero when empty so stale storage never shows.
    assign bus.oDt            = dtVld ? fifoMem[rdPtr] : 32'd0;
    assign bus.oDtVld         = dtVld;
    assign bus.oBusy          = busyC;
    assign bus.oDone          = doneC;

endmodule

// File: tb/tb_cp_outbuf_rdctrl.sv
// ---------------------------------------------------------------------------
// tb_cp_outbuf_rdctrl
// Directed scenarios with randomized buffer contents, addresses and ready
// patterns. The reference model is a list of expected read addresses and
// words built from the start address and block count, consumed in order as
// reads and transfers appear.
// ---------------------------------------------------------------------------
module tb_cp_outbuf_rdctrl;
    localparam int DEPTH = 2;

    logic iClk = 1'b0;
    logic iRst = 1'b1;

    cp_outbuf_rdctrl_if bus();

    cp_outbuf_rdctrl #(.P_FIFO_DEPTH(DEPTH)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    logic [31:0] obMem [512];
    int          nChk;
    int          nPass;
    int          cyc;
    int          rdyMode;
    logic        rdy;
    logic [6:0]  stAddrV;
    logic [7:0]  blkCntV;

    logic [8:0]  expAddrQ[$];
    logic [31:0] expWordQ[$];
    bit          active;
    int          doneDue, startCyc, issued, popped;
    int          firstRd, lastRd, firstWd, lastWd, doneSeen;
    logic [8:0]  firstAddr, lastAddr;
    bit          stallPrev;
    logic [31:0] stallDt;
    bit          lastRdEn;
    logic [8:0]  lastRdAddr;
    bit          rstPrev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clearModel();
        expAddrQ.delete();
        expWordQ.delete();
        active    = 1'b0;
        doneDue   = -1;
        stallPrev = 1'b0;
        issued    = 0;
        popped    = 0;
    endtask

    task automatic beginRun();
        int a;
        startCyc = cyc;
        active   = 1'b1;
        issued   = 0;
        popped   = 0;
        firstRd  = -1; lastRd = -1; firstWd = -1; lastWd = -1; doneSeen = -1;
        for (int i = 0; i < int'(blkCntV) * 4; i++) begin
            a = (int'(stAddrV) * 4 + i) % 512;
            expAddrQ.push_back(9'(a));
            expWordQ.push_back(obMem[a]);
        end
        doneDue = (blkCntV == 8'd0) ? cyc + 1 : -1;
    endtask

    task automatic observe();
        if (active) chk("credit", 32'((issued - popped) <= DEPTH), 32'd1);
        if (bus.oRdEn_OutBuf) begin
            if (expAddrQ.size() != 0) begin
                if (issued == 0) begin
                    firstRd   = cyc;
                    firstAddr = bus.oRdAddr_OutBuf;
                end
                lastRd   = cyc;
                lastAddr = bus.oRdAddr_OutBuf;
                issued++;
                chk("rdAddr", 32'(bus.oRdAddr_OutBuf), 32'(expAddrQ.pop_front()));
            end else begin
                chk("spuriousRd", 32'(bus.oRdEn_OutBuf), 32'd0);
            end
        end
        lastRdEn   = bus.oRdEn_OutBuf;
        lastRdAddr = bus.oRdAddr_OutBuf;
        if (stallPrev) begin
            chk("stallVld", 32'(bus.oDtVld), 32'd1);
            chk("stallDt", bus.oDt, stallDt);
        end
        if (bus.oDtVld && bus.iDtRdy) begin
            if (expWordQ.size() != 0) begin
                if (popped == 0) firstWd = cyc;
                lastWd = cyc;
                popped++;
                chk("oDt", bus.oDt, expWordQ.pop_front());
                if (expWordQ.size() == 0) doneDue = cyc + 1;
            end else begin
                chk("spuriousWord", 32'(bus.oDtVld), 32'd0);
            end
        end
        stallPrev = bus.oDtVld && !bus.iDtRdy;
        stallDt   = bus.oDt;
        if (!active) chk("idleVld", 32'(bus.oDtVld), 32'd0);
        chk("oBusy", 32'(bus.oBusy), 32'(active));
        chk("oDone", 32'(bus.oDone), 32'(cyc == doneDue));
        if (bus.oDone) doneSeen = cyc;
        if (cyc == doneDue) active = 1'b0;
    endtask

    // One clock cycle: inputs applied just after the rising edge, outputs
    // sampled on the falling edge, then the model reacts to the inputs.
    task automatic step(input bit start, input bit abort, input bit rst);
        @(posedge iClk);
        #1;
        bus.iRdDt_OutBuf = lastRdEn ? obMem[lastRdAddr] : $urandom();
        iRst        = rst;
        bus.iStart  = start;
        bus.iAbort  = abort;
        bus.iStAddr = stAddrV;
        bus.iBlkCnt = blkCntV;
        if (rdyMode == 0)      rdy = 1'b1;
        else if (rdyMode == 1) rdy = ~rdy;
        else                   rdy = 1'($urandom_range(0, 1));
        bus.iDtRdy = rdy;
        cyc++;
        @(negedge iClk);
        observe();
        if (rst && rstPrev) begin
            chk("rstRdEn", 32'(bus.oRdEn_OutBuf), 32'd0);
            chk("rstAddr", 32'(bus.oRdAddr_OutBuf), 32'd0);
            chk("rstDt",   bus.oDt, 32'd0);
            chk("rstVld",  32'(bus.oDtVld), 32'd0);
            chk("rstBusy", 32'(bus.oBusy), 32'd0);
            chk("rstDone", 32'(bus.oDone), 32'd0);
        end
        rstPrev = rst;
        if (rst || (abort && active)) clearModel();
        else if (start && !abort && !active) beginRun();
    endtask

    task automatic runTo(input int maxC);
        int n;
        n = 0;
        while (active && n < maxC) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("timeout", 32'(active), 32'd0);
        chk("wordsLeft", 32'(expWordQ.size()), 32'd0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic waitWords(input int w);
        int n;
        n = 0;
        while (popped < w && n < 200) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("wordWait", 32'(popped >= w), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) obMem[i] = $urandom();
        bus.iStart = 1'b0; bus.iAbort = 1'b0; bus.iStAddr = '0; bus.iBlkCnt = '0;
        bus.iRdDt_OutBuf = '0; bus.iDtRdy = 1'b1;
        nChk = 0; nPass = 0; cyc = 0; rdyMode = 0; rdy = 1'b1;
        stAddrV = '0; blkCntV = '0; lastRdEn = 1'b0; lastRdAddr = '0; rstPrev = 1'b0;
        firstAddr = '0; lastAddr = '0; stallDt = '0;
        clearModel();

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Full-rate run: 8 reads at 20..27, words in cycles 3..10, done in 11
        rdyMode = 0; stAddrV = 7'd5; blkCntV = 8'd2;
        step(1'b1, 1'b0, 1'b0);
        runTo(50);
        chk("fullFirstRd", 32'(firstRd - startCyc), 32'd1);
        chk("fullLastRd",  32'(lastRd - startCyc), 32'd8);
        chk("fullFirstWd", 32'(firstWd - startCyc), 32'd3);
        chk("fullLastWd",  32'(lastWd - startCyc), 32'd10);
        chk("fullDone",    32'(doneSeen - startCyc), 32'd11);
        chk("fullAddr0",   32'(firstAddr), 32'd20);
        chk("fullAddr7",   32'(lastAddr), 32'd27);

        // Backpressure: ready toggling
        rdyMode = 1; stAddrV = 7'd40; blkCntV = 8'd6;
        step(1'b1, 1'b0, 1'b0);
        runTo(300);
        chk("bpWords", 32'(popped), 32'd24);

        // Random ready, random ranges
        rdyMode = 2;
        for (int k = 0; k < 3; k++) begin
            stAddrV = 7'($urandom_range(0, 127));
            blkCntV = 8'($urandom_range(1, 8));
            step(1'b1, 1'b0, 1'b0);
            runTo(400);
            chk("rndWords", 32'(popped), 32'(int'(blkCntV) * 4));
        end

        // Address wrap: 508..511 then 0..3
        rdyMode = 0; stAddrV = 7'd127; blkCntV = 8'd2;
        step(1'b1, 1'b0, 1'b0);
        runTo(50);
        chk("wrapFirst", 32'(firstAddr), 32'd508);
        chk("wrapLast",  32'(lastAddr), 32'd3);

        // Maximum count with random ready
        rdyMode = 2; stAddrV = 7'($urandom_range(0, 127)); blkCntV = 8'd128;
        step(1'b1, 1'b0, 1'b0);
        runTo(5000);
        chk("maxWords", 32'(popped), 32'd512);

        // Zero count: no reads, completion pulse right after the start edge
        rdyMode = 0; blkCntV = 8'd0;
        step(1'b1, 1'b0, 1'b0);
        runTo(10);
        chk("zeroReads", 32'(issued), 32'd0);
        chk("zeroDone",  32'(doneSeen - startCyc), 32'd1);

        // Abort after word 5 of 16
        stAddrV = 7'd30; blkCntV = 8'd4;
        step(1'b1, 1'b0, 1'b0);
        waitWords(5);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("abortBusy", 32'(bus.oBusy), 32'd0);
        chk("abortVld",  32'(bus.oDtVld), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0);
        stAddrV = 7'd9; blkCntV = 8'd2;
        step(1'b1, 1'b0, 1'b0);
        runTo(50);
        chk("postAbortFirstWd", 32'(firstWd - startCyc), 32'd3);
        chk("postAbortDone",    32'(doneSeen - startCyc), 32'd11);

        // Reset mid-drain
        rdyMode = 2; stAddrV = 7'd64; blkCntV = 8'd4;
        step(1'b1, 1'b0, 1'b0);
        waitWords(5);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        rdyMode = 0; stAddrV = 7'd100; blkCntV = 8'd2;
        step(1'b1, 1'b0, 1'b0);
        runTo(50);
        chk("postRstWords", 32'(popped), 32'd8);

        // Start while busy is ignored
        rdyMode = 2; stAddrV = 7'd10; blkCntV = 8'd3;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        stAddrV = 7'd99; blkCntV = 8'd7;
        step(1'b1, 1'b0, 1'b0);
        runTo(300);
        chk("ignWords", 32'(popped), 32'd12);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
